boss_bullet: RTL and testbench
==============================

BOSS_BULLET -- requirements
Module: boss_bullet

Interface
REQ-001 SHALL have parameter FIRE_PERIOD, default 8, meaning clk_22 cycles between fire attempts.
REQ-002 SHALL have parameter SPEED, default 12, meaning pixels of downward travel per cycle.
REQ-003 SHALL have parameter BOTTOM, default 480, meaning the first y value that is off-screen.
REQ-004 SHALL have parameter HIT_R, default 8, meaning the hit half-width applied to both x and y.
REQ-005 SHALL have parameter INVINC_TICKS, default 32, meaning cycles of invincibility after a hit.
REQ-006 SHALL have parameter LIVES_INIT, default 3, meaning the starting life count.
REQ-007 SHALL have port clk_22, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port fire_en, input, 1 bit: boss firing enable.
REQ-010 SHALL have ports bossx and bossy, input, 10 bits each: the boss spawn point.
REQ-011 SHALL have ports reimux and reimuy, input, 10 bits each: the player centre.
REQ-012 SHALL have port boss_bulletx, output, 40 bits: slot i x position at bits [10i+9:10i].
REQ-013 SHALL have port boss_bullety, output, 40 bits: slot i y position, packed the same way.
REQ-014 SHALL have port boss_bullet_vld, output, 4 bits: slot active flags.
REQ-015 SHALL have port reimu_hit, output, 1 bit: one-cycle pulse per accepted hit.
REQ-016 SHALL have port reimu_lives, output, 3 bits: remaining lives.
REQ-017 SHALL have port invinc, output, 1 bit: high while invincible.
REQ-018 SHALL have port game_over, output, 1 bit: high when reimu_lives is 0.

Function
REQ-019 SHALL implement a game FSM with states PLAY, INVINC and OVER.
REQ-020 SHALL use fire counter fire_cnt, counting 0..FIRE_PERIOD-1 and wrapping; it counts in every state.
REQ-021 SHALL attempt a fire when fire_cnt==FIRE_PERIOD-1, fire_en=1 and state!=OVER.
REQ-022 SHALL, on a fire attempt, load the lowest-index slot with vld=0 (sampled at cycle start) with (bossx, bossy) and set its vld.
REQ-023 SHALL drop the shot silently when all 4 slots are valid.
REQ-024 SHALL NOT reuse a slot freed in cycle N before cycle N+1.
REQ-025 SHALL, per valid slot and per cycle with priority hit > exit > move: hit clears vld; exit (y+SPEED >= BOTTOM, computed at 11 bits) clears vld; otherwise y <= y+SPEED and x holds.
REQ-026 SHALL define a slot hit as vld, |x-reimux| <= HIT_R and |y-reimuy| <= HIT_R, using pre-move values, in state PLAY only.
REQ-027 SHALL compute the hit differences at 11-bit signed width, with no 10-bit wrap.
REQ-028 SHALL, when one or more slots hit in the same cycle, clear all hitting slots and decrement lives by exactly 1; reimu_hit pulses for one cycle.
REQ-029 SHALL, on a hit in PLAY: go to OVER if lives becomes 0; otherwise go to INVINC and load invinc_cnt=INVINC_TICKS-1.
REQ-030 SHALL, in INVINC, decrement invinc_cnt each cycle, let bullets pass through reimu, and return to PLAY on the cycle after invinc_cnt==0.
REQ-031 SHALL hold invinc high in INVINC only.
REQ-032 SHALL, in OVER, stop firing, keep moving existing bullets until they exit, hold game_over=1, and leave OVER only by rst.
REQ-033 SHALL drive all outputs directly from registers.

Reset
REQ-034 SHALL, while rst=1 (asynchronous), hold state=PLAY, fire_cnt=0, invinc_cnt=0, all vld=0, all x/y=0, reimu_hit=0, reimu_lives=LIVES_INIT, invinc=0 and game_over=0.
REQ-035 SHALL, on rst assertion mid-flight, immediately discard all bullets and any pending hit.

Structure
REQ-036 SHALL place NUM_SLOTS=4, the coordinate width of 10 and the FSM state encodings in a shared game package, alongside reimu_bullet's constants.
REQ-037 SHALL instantiate sub-module bullet_slot once per slot; each instance holds x, y and vld and performs spawn, move and exit, and boss_bullet owns the FSM, the allocator and the hit combine.

Verification
REQ-038 SHALL verify spawn: fire_en=1, bossx=320, bossy=40 -> slot0 vld at cycle 8 with y=40, then y=52 at cycle 9.
REQ-039 SHALL verify exit: slot at y=468 -> vld clears next cycle (468+12 >= 480) and y does not wrap.
REQ-040 SHALL verify full pool: 4 slots valid at a fire tick -> no spawn, vld stays 4'b1111; a slot freed on the fire tick is refilled only at the next fire tick.
REQ-041 SHALL verify hit: reimux=100, reimuy=300, bullet x=105, y=295 -> reimu_hit pulse, lives 3->2, slot cleared, invinc high for 32 cycles.
REQ-042 SHALL verify double hit: two slots overlapping reimu in the same cycle -> lives decrements once; a bullet overlapping during invinc passes through.
REQ-043 SHALL verify game over: third hit -> lives=0, game_over=1, no further spawns; rst mid-game -> lives=3 and vld=0.

Source files
------------

// File: rtl/game_pkg.sv
// Constants and types shared by the game blocks: boss shot pool, player shot pool and game FSM.
package game_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int COORD_W   = 10;
  localparam int WIDE_W    = COORD_W + 1;

  // Player shot pool (reimu_bullet) uses the same coordinate space.
  localparam int REIMU_NUM_SLOTS = 4;
  localparam int REIMU_SPEED     = 16;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_INVINC = 2'd1,
    ST_OVER   = 2'd2
  } game_state_e;

  // Distance between two screen coordinates, taken one bit wider so it never wraps.
  function automatic logic [WIDE_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic signed [WIDE_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? WIDE_W'(-d) : WIDE_W'(d);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One boss bullet: holds position and valid, spawns on request, falls SPEED per cycle, retires at BOTTOM.
module bullet_slot
  import game_pkg::*;
#(
  parameter int SPEED  = 12,
  parameter int BOTTOM = 480
) (
  input  logic               clk_22,
  input  logic               rst,
  input  logic               spawn_i,
  input  logic               clr_i,
  input  logic [COORD_W-1:0] spawn_x_i,
  input  logic [COORD_W-1:0] spawn_y_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               vld_o
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               vld_q, vld_d;
  logic [WIDE_W-1:0]  y_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    y_next = {1'b0, y_q} + WIDE_W'(SPEED);
    x_d    = x_q;
    y_d    = y_q;
    vld_d  = vld_q;
    if (vld_q) begin
      // A hit outranks leaving the screen; a retired bullet keeps its last y.
      if (clr_i || (y_next >= WIDE_W'(BOTTOM))) vld_d = 1'b0;
      else                                      y_d   = y_next[COORD_W-1:0];
    end else if (spawn_i) begin
      x_d   = spawn_x_i;
      y_d   = spawn_y_i;
      vld_d = 1'b1;
    end
  end

  // NOTE: position registers are reset too, so a freshly reset screen reports all-zero coordinates.
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      x_q   <= x_d;
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/boss_bullet.sv
// Boss bullet pool: periodic fire into the lowest free slot, hit detection against the player, lives/invincibility FSM.
module boss_bullet
  import game_pkg::*;
#(
  parameter int FIRE_PERIOD  = 8,
  parameter int SPEED        = 12,
  parameter int BOTTOM       = 480,
  parameter int HIT_R        = 8,
  parameter int INVINC_TICKS = 32,
  parameter int LIVES_INIT   = 3
) (
  input  logic                           clk_22,
  input  logic                           rst,
  input  logic                           fire_en,
  input  logic [COORD_W-1:0]             bossx,
  input  logic [COORD_W-1:0]             bossy,
  input  logic [COORD_W-1:0]             reimux,
  input  logic [COORD_W-1:0]             reimuy,
  output logic [NUM_SLOTS*COORD_W-1:0]   boss_bulletx,
  output logic [NUM_SLOTS*COORD_W-1:0]   boss_bullety,
  output logic [NUM_SLOTS-1:0]           boss_bullet_vld,
  output logic                           reimu_hit,
  output logic [2:0]                     reimu_lives,
  output logic                           invinc,
  output logic                           game_over
);

  localparam int FW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam int IW = (INVINC_TICKS > 1) ? $clog2(INVINC_TICKS) : 1;

  game_state_e        state_q;
  logic [FW-1:0]      fire_cnt_q;
  logic [IW-1:0]      invinc_cnt_q;
  logic               hit_q;
  logic [2:0]         lives_q;
  logic               invinc_q;
  logic               game_over_q;

  logic [COORD_W-1:0] slot_x [NUM_SLOTS];
  logic [COORD_W-1:0] slot_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_vld, hit_vec, spawn_vec;
  logic               fire_wrap, fire_try;

  assign fire_wrap = (fire_cnt_q == FW'(FIRE_PERIOD - 1));
  assign fire_try  = fire_wrap && fire_en && (state_q != ST_OVER);

  // Allocation looks at valid flags from the start of the cycle, so a slot freed now is reusable next cycle.
  always_comb begin
    spawn_vec = '0;
    if (fire_try) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (!slot_vld[i]) begin
          spawn_vec    = '0;
          spawn_vec[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_vec[i] = (state_q == ST_PLAY) && slot_vld[i]
                && (abs_diff(slot_x[i], reimux) <= WIDE_W'(HIT_R))
                && (abs_diff(slot_y[i], reimuy) <= WIDE_W'(HIT_R));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bullet_slot #(
      .SPEED  (SPEED),
      .BOTTOM (BOTTOM)
    ) u_slot (
      .clk_22    (clk_22),
      .rst       (rst),
      .spawn_i   (spawn_vec[g]),
      .clr_i     (hit_vec[g]),
      .spawn_x_i (bossx),
      .spawn_y_i (bossy),
      .x_o       (slot_x[g]),
      .y_o       (slot_y[g]),
      .vld_o     (slot_vld[g])
    );
    assign boss_bulletx[g*COORD_W +: COORD_W] = slot_x[g];
    assign boss_bullety[g*COORD_W +: COORD_W] = slot_y[g];
  end

  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PLAY;
      fire_cnt_q   <= '0;
      invinc_cnt_q <= '0;
      hit_q        <= 1'b0;
      lives_q      <= 3'(LIVES_INIT);
      invinc_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      fire_cnt_q <= fire_wrap ? '0 : fire_cnt_q + 1'b1;
      hit_q      <= 1'b0;
      case (state_q)
        ST_PLAY: begin
          // Any number of simultaneous hits costs exactly one life.
          if (|hit_vec) begin
            hit_q   <= 1'b1;
            lives_q <= lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q      <= ST_INVINC;
              invinc_cnt_q <= IW'(INVINC_TICKS - 1);
              invinc_q     <= 1'b1;
            end
          end
        end
        ST_INVINC: begin
          if (invinc_cnt_q == '0) begin
            state_q  <= ST_PLAY;
            invinc_q <= 1'b0;
          end else begin
            invinc_cnt_q <= invinc_cnt_q - 1'b1;
          end
        end
        ST_OVER:  game_over_q <= 1'b1;
        default:  state_q     <= ST_PLAY;
      endcase
    end
  end

  assign boss_bullet_vld = slot_vld;
  assign reimu_hit       = hit_q;
  assign reimu_lives     = lives_q;
  assign invinc          = invinc_q;
  assign game_over       = game_over_q;

endmodule

// File: tb/tb_boss_bullet.sv
// Scoreboard bench for boss_bullet: stimulus queues cycle-tagged expectations, a monitor compares them.
module tb_boss_bullet;

  typedef enum int {S_VLD, S_X, S_Y, S_HIT, S_LIVES, S_INV, S_OVER} sig_e;
  typedef struct {
    int   ep;
    int   cyc;
    sig_e sig;
    int   idx;
    int   val;
  } exp_t;

  logic        clk_22 = 1'b0;
  logic        rst    = 1'b0;
  logic        fire_en = 1'b0;
  logic [9:0]  bossx = '0, bossy = '0, reimux = '0, reimuy = '0;
  logic [39:0] boss_bulletx, boss_bullety;
  logic [3:0]  boss_bullet_vld;
  logic        reimu_hit;
  logic [2:0]  reimu_lives;
  logic        invinc, game_over;

  int   cyc = 0;
  int   epoch = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];
  int   hit_q[$];

  boss_bullet #(
    .FIRE_PERIOD  (8),
    .SPEED        (12),
    .BOTTOM       (480),
    .HIT_R        (8),
    .INVINC_TICKS (32),
    .LIVES_INIT   (3)
  ) dut (
    .clk_22          (clk_22),
    .rst             (rst),
    .fire_en         (fire_en),
    .bossx           (bossx),
    .bossy           (bossy),
    .reimux          (reimux),
    .reimuy          (reimuy),
    .boss_bulletx    (boss_bulletx),
    .boss_bullety    (boss_bullety),
    .boss_bullet_vld (boss_bullet_vld),
    .reimu_hit       (reimu_hit),
    .reimu_lives     (reimu_lives),
    .invinc          (invinc),
    .game_over       (game_over)
  );

  always #5 clk_22 = ~clk_22;

  // Cycle index: number of clock edges since reset was released.
  always @(posedge clk_22 or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic logic [9:0] sample(input sig_e s, input int idx);
    case (s)
      S_VLD:   return {6'd0, boss_bullet_vld};
      S_X:     return boss_bulletx[idx*10 +: 10];
      S_Y:     return boss_bullety[idx*10 +: 10];
      S_HIT:   return {9'd0, reimu_hit};
      S_LIVES: return {7'd0, reimu_lives};
      S_INV:   return {9'd0, invinc};
      S_OVER:  return {9'd0, game_over};
      default: return 10'd0;
    endcase
  endfunction

  task automatic exp_at(input int ep, input int c, input sig_e s, input int idx, input int v);
    exp_t e;
    e.ep = ep; e.cyc = c; e.sig = s; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_reset_state(input int ep);
    exp_at(ep, 0, S_VLD, 0, 0);
    exp_at(ep, 0, S_X, 0, 0);
    exp_at(ep, 0, S_Y, 0, 0);
    exp_at(ep, 0, S_HIT, 0, 0);
    exp_at(ep, 0, S_LIVES, 0, 3);
    exp_at(ep, 0, S_INV, 0, 0);
    exp_at(ep, 0, S_OVER, 0, 0);
  endtask

  // Monitor: timed expectations at each falling edge, plus one lives check per hit pulse.
  always @(negedge clk_22) begin : monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].ep == epoch && sb[i].cyc == cyc) begin
        check($sformatf("%s[%0d] ep%0d cyc%0d", sb[i].sig.name(), sb[i].idx, sb[i].ep, sb[i].cyc),
              sample(sb[i].sig, sb[i].idx), 10'(sb[i].val));
        sb.delete(i);
      end else if (sb[i].ep < epoch || (sb[i].ep == epoch && sb[i].cyc < cyc)) begin
        total++;
        $display("FAIL %s[%0d] ep%0d cyc%0d: not observed, run now at ep%0d cyc%0d",
                 sb[i].sig.name(), sb[i].idx, sb[i].ep, sb[i].cyc, epoch, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
    if (!rst && reimu_hit === 1'b1) begin
      if (hit_q.size() == 0) begin
        total++;
        $display("FAIL hit_event: unexpected reimu_hit at cyc %0d, lives %0d", cyc, reimu_lives);
      end else begin
        check($sformatf("hit_event_lives cyc%0d", cyc), {7'd0, reimu_lives}, 10'(hit_q.pop_front()));
      end
    end
  end

  task automatic at_cyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 300) begin
      @(negedge clk_22);
      guard++;
    end
    if (cyc != c) begin
      total++;
      $display("FAIL at_cyc: waiting for cycle %0d, stuck at %0d", c, cyc);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk_22);
    #2;
    epoch++;
    rst = 1'b1;
    repeat (2) @(negedge clk_22);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Spawn timing, then a reset while two bullets are in flight.
    exp_reset_state(1);
    exp_at(1, 7,  S_VLD, 0, 0);
    exp_at(1, 8,  S_VLD, 0, 1);
    exp_at(1, 8,  S_X,   0, 320);
    exp_at(1, 8,  S_Y,   0, 40);
    exp_at(1, 9,  S_Y,   0, 52);
    exp_at(1, 9,  S_VLD, 0, 1);
    exp_at(1, 16, S_VLD, 0, 3);
    exp_at(1, 16, S_Y,   0, 136);
    exp_at(1, 16, S_Y,   1, 40);
    fire_en = 1'b1; bossx = 10'd320; bossy = 10'd40; reimux = 10'd0; reimuy = 10'd0;
    pulse_reset();
    at_cyc(17);

    // Exit boundary and full pool: bullets from y=0, player far away in x.
    exp_reset_state(2);
    exp_at(2, 8,  S_VLD, 0, 4'b0001);
    exp_at(2, 8,  S_Y,   0, 0);
    exp_at(2, 40, S_VLD, 0, 4'b1111);
    exp_at(2, 46, S_Y,   0, 456);
    exp_at(2, 46, S_VLD, 0, 4'b1111);
    exp_at(2, 47, S_Y,   0, 468);
    exp_at(2, 47, S_VLD, 0, 4'b1111);
    exp_at(2, 48, S_VLD, 0, 4'b1110);
    exp_at(2, 48, S_Y,   0, 468);
    exp_at(2, 49, S_VLD, 0, 4'b1110);
    exp_at(2, 55, S_VLD, 0, 4'b1110);
    exp_at(2, 55, S_Y,   1, 468);
    exp_at(2, 56, S_VLD, 0, 4'b1101);
    exp_at(2, 56, S_Y,   0, 0);
    exp_at(2, 57, S_Y,   0, 12);
    exp_at(2, 64, S_VLD, 0, 4'b1011);
    exp_at(2, 64, S_Y,   1, 0);
    exp_at(2, 64, S_X,   1, 320);
    bossy = 10'd0;
    pulse_reset();
    at_cyc(65);

    // Hits: single, pass-through while invincible, double, and the final hit.
    exp_reset_state(3);
    exp_at(3, 8,  S_VLD,   0, 1);
    exp_at(3, 8,  S_X,     0, 105);
    exp_at(3, 8,  S_Y,     0, 295);
    exp_at(3, 8,  S_LIVES, 0, 3);
    exp_at(3, 9,  S_HIT,   0, 1);
    exp_at(3, 9,  S_LIVES, 0, 2);
    exp_at(3, 9,  S_INV,   0, 1);
    exp_at(3, 9,  S_VLD,   0, 0);
    exp_at(3, 9,  S_OVER,  0, 0);
    exp_at(3, 10, S_HIT,   0, 0);
    exp_at(3, 16, S_VLD,   0, 1);
    exp_at(3, 16, S_Y,     0, 295);
    exp_at(3, 17, S_Y,     0, 307);
    exp_at(3, 17, S_VLD,   0, 1);
    exp_at(3, 17, S_HIT,   0, 0);
    exp_at(3, 17, S_LIVES, 0, 2);
    exp_at(3, 31, S_Y,     0, 475);
    exp_at(3, 31, S_VLD,   0, 1);
    exp_at(3, 32, S_VLD,   0, 0);
    exp_at(3, 40, S_INV,   0, 1);
    exp_at(3, 41, S_INV,   0, 0);
    exp_at(3, 41, S_LIVES, 0, 2);
    exp_at(3, 48, S_VLD,   0, 1);
    exp_at(3, 48, S_Y,     0, 200);
    exp_at(3, 56, S_VLD,   0, 3);
    exp_at(3, 56, S_Y,     0, 296);
    exp_at(3, 56, S_Y,     1, 302);
    exp_at(3, 56, S_X,     1, 98);
    exp_at(3, 57, S_VLD,   0, 0);
    exp_at(3, 57, S_HIT,   0, 1);
    exp_at(3, 57, S_LIVES, 0, 1);
    exp_at(3, 57, S_INV,   0, 1);
    exp_at(3, 58, S_HIT,   0, 0);
    exp_at(3, 58, S_LIVES, 0, 1);
    exp_at(3, 88, S_INV,   0, 1);
    exp_at(3, 88, S_VLD,   0, 1);
    exp_at(3, 88, S_X,     0, 600);
    exp_at(3, 88, S_Y,     0, 0);
    exp_at(3, 89, S_INV,   0, 0);
    exp_at(3, 96, S_VLD,   0, 3);
    exp_at(3, 96, S_Y,     0, 96);
    exp_at(3, 96, S_Y,     1, 295);
    exp_at(3, 97, S_VLD,   0, 1);
    exp_at(3, 97, S_Y,     0, 108);
    exp_at(3, 97, S_LIVES, 0, 0);
    exp_at(3, 97, S_OVER,  0, 1);
    exp_at(3, 97, S_HIT,   0, 1);
    exp_at(3, 97, S_INV,   0, 0);
    exp_at(3, 98, S_HIT,   0, 0);
    exp_at(3, 98, S_Y,     0, 120);
    exp_at(3, 104, S_VLD,  0, 1);
    exp_at(3, 105, S_VLD,  0, 1);
    exp_at(3, 110, S_VLD,  0, 1);
    exp_at(3, 110, S_Y,    0, 264);
    exp_at(3, 110, S_OVER, 0, 1);
    hit_q.push_back(2);
    hit_q.push_back(1);
    hit_q.push_back(0);
    fire_en = 1'b1; bossx = 10'd105; bossy = 10'd295; reimux = 10'd100; reimuy = 10'd300;
    pulse_reset();
    at_cyc(17);
    fire_en = 1'b0;
    at_cyc(41);
    fire_en = 1'b1; bossx = 10'd105; bossy = 10'd200;
    at_cyc(48);
    bossx = 10'd98; bossy = 10'd302;
    at_cyc(57);
    fire_en = 1'b0;
    at_cyc(81);
    fire_en = 1'b1; bossx = 10'd600; bossy = 10'd0;
    at_cyc(89);
    bossx = 10'd105; bossy = 10'd295;
    at_cyc(110);

    // Reset out of game over with a bullet still falling; play resumes normally.
    exp_reset_state(4);
    exp_at(4, 8, S_VLD,   0, 1);
    exp_at(4, 8, S_Y,     0, 40);
    exp_at(4, 9, S_Y,     0, 52);
    exp_at(4, 9, S_LIVES, 0, 3);
    exp_at(4, 9, S_OVER,  0, 0);
    bossx = 10'd320; bossy = 10'd40; reimux = 10'd0; reimuy = 10'd0;
    pulse_reset();
    at_cyc(12);
    @(negedge clk_22);

    check("scoreboard_drained", 10'(sb.size()), 10'd0);
    check("hit_events_drained", 10'(hit_q.size()), 10'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
